// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU bus: operands, op code, start handshake and results.
interface alu_muldiv_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic                  alusrc;
    logic [3:0]            alucontrol;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] immext;
    logic [DATA_WIDTH-1:0] aluresult;
    logic                  zero;
    logic                  busy;
    logic                  done;

    modport master (
        output start, alusrc, alucontrol, rd1, rd2, immext,
        input  aluresult, zero, busy, done
    );

    modport slave (
        input  start, alusrc, alucontrol, rd1, rd2, immext,
        output aluresult, zero, busy, done
    );
endinterface

// File: rtl/alu_muldiv.sv
// RV32IM execute-stage ALU: single-cycle base ops plus an iterative
// shift-add multiplier / restoring divider (one bit per cycle).
// Optional macro ALU_MULDIV_BYPASS_EN: trivial M ops (srcb == 0, or
// rd1 == 0 for multiplies) complete at the start edge without CALC.
module alu_muldiv #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_muldiv_if.slave   bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_n;
    logic [W-1:0]    srcb, base_res;
    logic [W-1:0]    result_q;
    logic [W-1:0]    hi_q, lo_q, b_q;
    logic [W-1:0]    hi_n, lo_n;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            busy_q, done_q;
    logic            load, fin;

    // start-time operand decode
    logic [2:0]      op_in;
    logic            a_neg, b_neg, neg_in;
    logic [W-1:0]    a_mag, b_mag;

    // fix-up of the final step
    logic [2*W-1:0]  prod, prod_s;
    logic [W-1:0]    quo_s, rem_s, fin_res;

    // step datapath
    logic [W:0]      sum, rs;
    logic            ge;

`ifdef ALU_MULDIV_BYPASS_EN
    logic            byp, byp_hit;
    logic [W-1:0]    byp_res;
`endif

    assign srcb = bus.alusrc ? bus.immext : bus.rd2;

    // single-cycle base operations
    always_comb begin
        base_res = '0;
        case (bus.alucontrol[2:0])
            3'b000:  base_res = bus.rd1 + srcb;
            3'b001:  base_res = bus.rd1 - srcb;
            3'b010:  base_res = bus.rd1 & srcb;
            3'b011:  base_res = bus.rd1 | srcb;
            3'b101:  base_res = {{(W-1){1'b0}}, ($signed(bus.rd1) < $signed(srcb))};
            default: base_res = '0;
        endcase
    end

    assign bus.aluresult = bus.alucontrol[3] ? result_q : base_res;
    assign bus.zero      = (bus.aluresult == '0);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // operand signedness, magnitudes and result sign at launch
    always_comb begin
        op_in = bus.alucontrol[2:0];
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (!op_in[2]) begin
            a_neg = (op_in == 3'b001 || op_in == 3'b010) && bus.rd1[W-1];
            b_neg = (op_in == 3'b001) && srcb[W-1];
        end else begin
            a_neg = !op_in[0] && bus.rd1[W-1];
            b_neg = !op_in[0] && srcb[W-1];
        end
        a_mag = a_neg ? -bus.rd1 : bus.rd1;
        b_mag = b_neg ? -srcb : srcb;
        // divide by zero keeps the all-ones quotient unsigned; remainder follows the dividend
        if (!op_in[2])     neg_in = a_neg ^ b_neg;
        else if (op_in[1]) neg_in = a_neg;
        else               neg_in = (a_neg ^ b_neg) && (srcb != '0);
    end

`ifdef ALU_MULDIV_BYPASS_EN
    // trivial operations resolved at the start edge
    always_comb begin
        byp_hit = (srcb == '0) || (!op_in[2] && bus.rd1 == '0);
        if (!op_in[2])     byp_res = '0;
        else if (op_in[1]) byp_res = bus.rd1;
        else               byp_res = '1;
    end
`endif

    // one multiply (shift-add) or divide (restoring) step
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rs   = {hi_q, lo_q[W-1]};
        ge   = (rs >= {1'b0, b_q});
        if (!op_q[2]) begin
            hi_n = sum[W:1];
            lo_n = {sum[0], lo_q[W-1:1]};
        end else begin
            hi_n = ge ? W'(rs - {1'b0, b_q}) : rs[W-1:0];
            lo_n = {lo_q[W-2:0], ge};
        end
    end

    // sign fix-up and result select on the last step
    always_comb begin
        prod   = {hi_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_n : lo_n;
        rem_s  = neg_q ? -hi_n : hi_n;
        if (!op_q[2])      fin_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
        else if (op_q[1])  fin_res = rem_s;
        else               fin_res = quo_s;
    end

    // next-state and control strobes
    always_comb begin
        state_n = state_q;
        load    = 1'b0;
        fin     = 1'b0;
`ifdef ALU_MULDIV_BYPASS_EN
        byp     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && bus.alucontrol[3]) begin
                    load    = 1'b1;
                    state_n = CALC;
`ifdef ALU_MULDIV_BYPASS_EN
                    if (byp_hit) begin
                        byp     = 1'b1;
                        state_n = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (cnt_q == CW'(W - 1)) begin
                    fin     = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state, handshake flags and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            busy_q  <= (state_n == CALC);
            done_q  <= (state_n == DONE);
            if (load) begin
                op_q  <= op_in;
                neg_q <= neg_in;
                cnt_q <= '0;
                hi_q  <= '0;
                lo_q  <= op_in[2] ? a_mag : b_mag;
                b_q   <= op_in[2] ? b_mag : a_mag;
            end else if (state_q == CALC) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + CW'(1);
            end
            if (fin) result_q <= fin_res;
`ifdef ALU_MULDIV_BYPASS_EN
            if (byp) result_q <= byp_res;
`endif
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at DATA_WIDTH = 32.
module tb_alu_muldiv;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_muldiv_if #(.DATA_WIDTH(W)) bus ();

    alu_muldiv #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // launch one M op and follow it to its done pulse
    task automatic run_m(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_busy);
        int n;
        int busy_cnt;
        bus.alucontrol = op;
        bus.alusrc     = 1'b0;
        bus.rd1        = a;
        bus.rd2        = b;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rd1   = 32'h1234_5678;
        bus.rd2   = 32'h0000_0003;
        n         = 0;
        busy_cnt  = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_res"}, bus.aluresult, exp_res);
        check({tag, "_nobusy_at_done"}, {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int n;
        int dcnt;
        int bcnt;
        int dz_lat;
        int dz_busy;
        total = 0;
        bad   = 0;
`ifdef ALU_MULDIV_BYPASS_EN
        dz_lat  = 1;
        dz_busy = 0;
`else
        dz_lat  = 33;
        dz_busy = 32;
`endif
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.alusrc     = 1'b0;
        bus.alucontrol = 4'b1000;
        bus.rd1        = '0;
        bus.rd2        = '0;
        bus.immext     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.aluresult, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // base ops, combinational
        bus.rd1 = 32'd5; bus.rd2 = 32'd5; bus.alucontrol = 4'b0001; bus.alusrc = 1'b0;
        #1;
        check("sub_res", bus.aluresult, 32'd0);
        check("sub_zero", {31'b0, bus.zero}, 32'd1);
        bus.rd1 = 32'hFFFF_FFFE; bus.immext = 32'd1; bus.alusrc = 1'b1; bus.alucontrol = 4'b0101;
        #1;
        check("slt_res", bus.aluresult, 32'd1);
        check("slt_zero", {31'b0, bus.zero}, 32'd0);
        bus.rd1 = 32'd10; bus.rd2 = 32'h0000_0006; bus.alusrc = 1'b0; bus.alucontrol = 4'b0000;
        #1;
        check("add_res", bus.aluresult, 32'd16);
        bus.alucontrol = 4'b0010;
        #1;
        check("and_res", bus.aluresult, 32'd2);
        bus.alucontrol = 4'b0011;
        #1;
        check("or_res", bus.aluresult, 32'd14);
        bus.alucontrol = 4'b0111;
        #1;
        check("undef_base", bus.aluresult, 32'd0);

        // multiply family; first run_m follows directly after the base ops
        run_m("mul",    4'b1000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32);
        run_m("mulh",   4'b1001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 32);
        run_m("mulhu",  4'b1011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33, 32);
        run_m("mulhsu", 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32);

        // divide family, back-to-back starts on the cycle after done
        run_m("div",  4'b1100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
        run_m("rem",  4'b1110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
        run_m("divu", 4'b1101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 32);
        run_m("remu", 4'b1111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, 32);

        // corner cases
        run_m("div_ovf",  4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32);
        run_m("rem_ovf",  4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, 32);
        run_m("divu_dz",  4'b1101, 32'd123, 32'd0, 32'hFFFF_FFFF, dz_lat, dz_busy);
        run_m("remu_dz",  4'b1111, 32'd9, 32'd0, 32'd9, dz_lat, dz_busy);
        run_m("div_dz",   4'b1100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, dz_lat, dz_busy);
        run_m("rem_dz",   4'b1110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, dz_lat, dz_busy);

        // result register holds while base ops and idle cycles pass
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", bus.aluresult, 32'hFFFF_FFF9);

        // a second start during CALC is ignored
        bus.alucontrol = 4'b1000; bus.rd1 = 32'd7; bus.rd2 = 32'hFFFF_FFFD; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.rd1 = 32'd100; bus.rd2 = 32'd3; bus.alucontrol = 4'b1100; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 6;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ign_lat", 32'(n + 1), 32'd33);
        check("ign_res", bus.aluresult, 32'hFFFF_FFEB);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
        end
        check("ign_single_done", 32'(dcnt), 32'd0);

        // reset in the middle of a divide
        bus.alucontrol = 4'b1100; bus.rd1 = 32'd100; bus.rd2 = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        bus.alucontrol = 4'b1000;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_result", bus.aluresult, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        dcnt = 0;
        bcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
            if (bus.busy) bcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);
        check("midrst_no_busy", 32'(bcnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
